fft_sdf_bf_stage: RTL and testbench
===================================

# fft_sdf_bf_stage

Radix-2 DIF single-path delay-feedback (SDF) butterfly stage for the FFT pipeline. It accepts one complex sample per valid cycle and pairs sample k with sample k+HALF of each 2·HALF-point frame through an internal HALF-deep complex feedback delay. It emits the sum stream followed by the difference stream, tagged with twiddle-select information for the downstream twiddle multiplier. Stages are cascaded with HALF halving per stage.

## Interface
Parameters:
- DATA, 9, input sample width per real/imag component, signed
- HALF, 16, feedback delay depth and half frame length; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample present this cycle; no backpressure
- in_re, in_im  in  DATA  signed input sample
- flush  in  1  request drain of stored differences at a frame boundary
- out_valid  out  1  output sample valid
- out_re, out_im  out  DATA+1  signed butterfly output
- out_first  out  1  first output of a frame (sum, k=0)
- out_tw_sel  out  1  0 = sum output, 1 = difference output (needs twiddle)
- out_idx  out  $clog2(HALF)  butterfly index k within the half frame
- drop_err  out  1  sticky: in_valid arrived during DRAIN

## Operation
- Counter cnt, range 0..2·HALF-1. It advances by one per accepted sample and wraps to 0. Phase 0 is cnt<HALF; phase 1 is cnt≥HALF; k = cnt mod HALF.
- The feedback delay holds HALF complex words of width DATA+1. It shifts only on an accepted sample or on a drain cycle. Its head is the word written HALF shifts earlier.
- States:
  - IDLE: outputs invalid. An accepted sample is written to the delay (sign-extended), cnt=1, go to FILL.
  - FILL: each accepted sample is written to the delay and produces no output. After accepting the sample at cnt=HALF-1, go to RUN with cnt=HALF.
  - RUN, phase 1, accepted b with head a: output a+b (tw_sel=0, idx=k, first=(k==0)); write a−b to the delay.
  - RUN, phase 0, accepted x: output the head (stored difference, tw_sel=1, idx=k); write sign-extended x.
  - RUN with cnt==0 and flush=1 and in_valid=0: go to DRAIN.
  - DRAIN: for HALF consecutive cycles, output the head (tw_sel=1, idx=0..HALF-1) and shift in 0. After the last of these cycles, go to IDLE with cnt=0.
- flush has no effect outside RUN with cnt==0.
- If in_valid and flush are both high in RUN with cnt==0, the sample is accepted as phase 0 and flush is ignored.
- in_valid in DRAIN drops the sample and sets drop_err. drop_err clears only on rst.
- in_valid low in FILL or RUN stalls the stage: cnt, the delay and the state hold, and out_valid=0 next cycle.
- Arithmetic: full precision with one bit of growth, no rounding, no saturation. Overflow is impossible because inputs are DATA bits and outputs are DATA+1 bits.

## Timing
- All outputs are registered. An output appears exactly one cycle after the accepting (or drain) cycle.
- Reset values: out_valid=0, out_re=out_im=0, out_first=0, out_tw_sel=0, out_idx=0, drop_err=0, state=IDLE, cnt=0, all delay words 0.
- First-output latency from the first sample of a frame is HALF+1 cycles (continuous input).
- With continuous frames, throughput is one output per cycle. Order: HALF sums of frame n, then HALF differences of frame n interleaved in time with the phase 0 of frame n+1.
- rst mid-frame or mid-drain discards all stored data. The next sample after rst is treated as k=0 of a new frame.

## Structure
- Shared package fft_pkg holds:
  - the state enum (IDLE, FILL, RUN, DRAIN)
  - the helper for widths derived from HALF
  - the typedef for a complex sample of a parameterized width
- Sub-module fft_fb_delay: HALF-deep, enable-gated complex delay of width DATA+1 with synchronous clear. The FSM, counter, butterfly adders and output registers stay in the top module.

## Test plan
- HALF=4, DATA=9. Feed re 1..8 continuously (im=0), then assert flush → sums 6, 8, 10, 12 (out_first on 6, tw_sel=0, idx 0..3), then differences −4 ×4 (tw_sel=1, idx 0..3) on 4 consecutive drain cycles. Then IDLE.
- Two back-to-back frames 1..8 and 11..18 → frame 2's phase 0 outputs −4 ×4 while accepting 11..14. Then sums 26, 28, 30, 32.
- Extremes: all inputs re=−256, im=255 → sums re=−512, im=510; differences 0, with no wrap.
- Stall: drop in_valid for 3 cycles at cnt=2 and at cnt=5 → outputs identical to the continuous case, only delayed. out_valid=0 during the gaps.
- in_valid during DRAIN → sample dropped, drop_err=1 and held. Drain outputs unchanged.
- Assert rst at cnt=6 of frame 1, then feed 1..8 and flush → outputs are exactly those of the first test.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg : shared state encoding and width helpers for the SDF FFT stages
// Rev 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } fft_state_t;

  // Index width for a half frame; a one-bit floor keeps degenerate sizes legal.
  function automatic int unsigned idx_w(input int unsigned half);
    return (half < 2) ? 1 : $clog2(half);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_fb_delay.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_fb_delay : DEPTH-deep enable-gated complex shift delay, synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_fb_delay #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] din_re,
  input  logic signed [W-1:0] din_im,
  output logic signed [W-1:0] head_re,
  output logic signed [W-1:0] head_im
);

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } cplx_t;

  cplx_t mem_q [DEPTH];
  cplx_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = '{re: din_re, im: din_im};
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head_re = $signed(mem_q[DEPTH-1].re);
  assign head_im = $signed(mem_q[DEPTH-1].im);

endmodule
`default_nettype wire

// File: rtl/fft_sdf_bf_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_sdf_bf_stage : radix-2 DIF single-path delay-feedback butterfly stage
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_sdf_bf_stage
  import fft_pkg::*;
#(
  parameter int DATA = 9,
  parameter int HALF = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic signed [DATA-1:0]         in_re,
  input  logic signed [DATA-1:0]         in_im,
  input  logic                           flush,
  output logic                           out_valid,
  output logic signed [DATA:0]           out_re,
  output logic signed [DATA:0]           out_im,
  output logic                           out_first,
  output logic                           out_tw_sel,
  output logic [idx_w(HALF)-1:0]         out_idx,
  output logic                           drop_err
);

  localparam int IW = idx_w(HALF);
  localparam int CW = IW + 1;
  localparam int OW = DATA + 1;

  fft_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_re_q, out_re_d;
  logic signed [OW-1:0] out_im_q, out_im_d;
  logic                out_first_q, out_first_d;
  logic                out_tw_sel_q, out_tw_sel_d;
  logic [IW-1:0]       out_idx_q, out_idx_d;
  logic                drop_err_q, drop_err_d;

  logic                dl_en;
  logic signed [OW-1:0] dl_re, dl_im;
  logic signed [OW-1:0] head_re, head_im;
  logic signed [OW-1:0] x_re, x_im;
  logic [IW-1:0]       k;
  logic                phase1;

  assign x_re   = {in_re[DATA-1], in_re};
  assign x_im   = {in_im[DATA-1], in_im};
  assign k      = cnt_q[IW-1:0];
  assign phase1 = cnt_q[IW];

  fft_fb_delay #(
    .W     (OW),
    .DEPTH (HALF)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .en      (dl_en),
    .din_re  (dl_re),
    .din_im  (dl_im),
    .head_re (head_re),
    .head_im (head_im)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    out_re_d     = out_re_q;
    out_im_d     = out_im_q;
    out_first_d  = out_first_q;
    out_tw_sel_d = out_tw_sel_q;
    out_idx_d    = out_idx_q;
    drop_err_d   = drop_err_q;
    dl_en        = 1'b0;
    dl_re        = x_re;
    dl_im        = x_im;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dl_en   = 1'b1;
          cnt_d   = CW'(1);
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          dl_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(HALF - 1)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          dl_en       = 1'b1;
          out_valid_d = 1'b1;
          out_idx_d   = k;
          cnt_d       = cnt_q + 1'b1;
          if (phase1) begin
            // Head holds sample k; the sum leaves now, the difference recirculates.
            out_re_d     = head_re + x_re;
            out_im_d     = head_im + x_im;
            out_tw_sel_d = 1'b0;
            out_first_d  = (k == '0);
            dl_re        = head_re - x_re;
            dl_im        = head_im - x_im;
          end else begin
            out_re_d     = head_re;
            out_im_d     = head_im;
            out_tw_sel_d = 1'b1;
            out_first_d  = 1'b0;
          end
        end else if (flush && (cnt_q == '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        dl_en        = 1'b1;
        dl_re        = '0;
        dl_im        = '0;
        out_valid_d  = 1'b1;
        out_re_d     = head_re;
        out_im_d     = head_im;
        out_tw_sel_d = 1'b1;
        out_first_d  = 1'b0;
        out_idx_d    = k;
        if (in_valid) begin
          drop_err_d = 1'b1;
        end
        if (cnt_q == CW'(HALF - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_re_q     <= '0;
      out_im_q     <= '0;
      out_first_q  <= 1'b0;
      out_tw_sel_q <= 1'b0;
      out_idx_q    <= '0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_re_q     <= out_re_d;
      out_im_q     <= out_im_d;
      out_first_q  <= out_first_d;
      out_tw_sel_q <= out_tw_sel_d;
      out_idx_q    <= out_idx_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_re     = out_re_q;
  assign out_im     = out_im_q;
  assign out_first  = out_first_q;
  assign out_tw_sel = out_tw_sel_q;
  assign out_idx    = out_idx_q;
  assign drop_err   = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_sdf_bf_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_sdf_bf_stage : scoreboard bench, frame-level butterfly model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fft_sdf_bf_stage;

  localparam int DATA = 9;
  localparam int HALF = 4;
  localparam int N    = 2 * HALF;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic signed [DATA-1:0] in_re, in_im;
  logic                   flush;
  logic                   out_valid;
  logic signed [DATA:0]   out_re, out_im;
  logic                   out_first, out_tw_sel;
  logic [1:0]             out_idx;
  logic                   drop_err;

  fft_sdf_bf_stage #(.DATA(DATA), .HALF(HALF)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_re      (in_re),
    .in_im      (in_im),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_first  (out_first),
    .out_tw_sel (out_tw_sel),
    .out_idx    (out_idx),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int stamp;
    int re;
    int im;
    int first;
    int tw;
    int idx;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Frame model: the current frame's samples and the previous frame's differences.
  int fr_re[N], fr_im[N];
  int pd_re[HALF], pd_im[HALF];
  int pos = 0;
  bit have_prev = 1'b0;

  task automatic push(input int stamp, input int re, input int im,
                      input int first, input int tw, input int idx);
    exp_t e;
    e.stamp = stamp; e.re = re; e.im = im;
    e.first = first; e.tw = tw; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic send(input int re, input int im);
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b0;
    in_re = DATA'(re); in_im = DATA'(im);
    if (pos < HALF) begin
      if (have_prev) push(cyc + 1, pd_re[pos], pd_im[pos], 0, 1, pos);
    end else begin
      push(cyc + 1, fr_re[pos-HALF] + re, fr_im[pos-HALF] + im,
           (pos == HALF) ? 1 : 0, 0, pos - HALF);
    end
    fr_re[pos] = re; fr_im[pos] = im;
    if (pos == N - 1) begin
      for (int k = 0; k < HALF; k++) begin
        pd_re[k] = fr_re[k] - fr_re[k+HALF];
        pd_im[k] = fr_im[k] - fr_im[k+HALF];
      end
      have_prev = 1'b1;
    end
    pos = (pos + 1) % N;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
    end
  endtask

  task automatic do_flush(input bit poke);
    int base;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    base = cyc;
    for (int k = 0; k < HALF; k++) push(base + 2 + k, pd_re[k], pd_im[k], 0, 1, k);
    have_prev = 1'b0;
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk);
      flush = 1'b0;
      in_valid = poke && (k == 1);
      in_re = 9'sd77; in_im = -9'sd3;
    end
    idle(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_time", cyc, e.stamp);
        check("out_re", $signed(out_re), e.re);
        check("out_im", $signed(out_im), e.im);
        check("out_first", out_first, e.first);
        check("out_tw_sel", out_tw_sel, e.tw);
        check("out_idx", out_idx, e.idx);
      end
    end else if (out_valid !== 1'b0) begin
      check("out_valid_x", out_valid, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_re = '0; in_im = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", $signed(out_re), 0);
    check("rst_out_im", $signed(out_im), 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_tw_sel", out_tw_sel, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_drop_err", drop_err, 0);
    rst = 1'b0;

    // Single frame then drain
    for (int i = 1; i <= N; i++) send(i, 0);
    do_flush(1'b0);
    idle(2);

    // Back-to-back frames
    for (int i = 1; i <= N; i++) send(i, 0);
    for (int i = 11; i <= 10 + N; i++) send(i, 0);
    do_flush(1'b0);
    idle(2);

    // Input extremes
    for (int i = 0; i < N; i++) send(-256, 255);
    do_flush(1'b0);
    idle(2);

    // Stalls before cnt=2 and cnt=5
    for (int i = 1; i <= N; i++) begin
      if (i == 3 || i == 6) idle(3);
      send(i, 2 * i);
    end
    do_flush(1'b0);
    idle(2);
    check("drop_err_clear", drop_err, 0);

    // Sample arriving during drain
    for (int i = 1; i <= N; i++) send(i, -i);
    do_flush(1'b1);
    check("drop_err_set", drop_err, 1);
    idle(3);
    check("drop_err_held", drop_err, 1);

    // Reset mid-frame at cnt=6
    for (int i = 1; i <= 6; i++) send(i, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pos = 0; have_prev = 1'b0;
    check("rst_mid_drop_err", drop_err, 0);
    check("rst_mid_out_valid", out_valid, 0);
    for (int i = 1; i <= N; i++) send(i, 0);
    do_flush(1'b0);
    idle(5);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
